// File: rtl/fma_pkg.sv
// Shared definitions for the fixed-point multiply-add lane bank: lane field
// layout, pipeline state encoding and the saturating resize helper.
package fma_pkg;

    localparam int unsigned DEF_WIDTH   = 16;
    localparam int unsigned A_LSB       = 0;
    localparam int unsigned B_LSB       = DEF_WIDTH;
    localparam int unsigned C_LSB       = 2 * DEF_WIDTH;
    localparam int unsigned LANE_STRIDE = 3 * DEF_WIDTH;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] value;
        logic                        clipped;
    } sat_t;

    // Treats the low in_w bits of v as signed and clamps them to out_w bits.
    function automatic sat_t sat_resize(input logic signed [SAT_MAX_W-1:0] v,
                                        input int unsigned in_w,
                                        input int unsigned out_w);
        logic signed [SAT_MAX_W-1:0] v_ext;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_t                        r;
        v_ext = (v <<< (SAT_MAX_W - in_w)) >>> (SAT_MAX_W - in_w);
        hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo    = ~hi;
        if (v_ext > hi) begin
            r.value   = hi;
            r.clipped = 1'b1;
        end else if (v_ext < lo) begin
            r.value   = lo;
            r.clipped = 1'b1;
        end else begin
            r.value   = v_ext;
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fma_lane_bank_if.sv
// Beat input and packed result bus between the memory buffer, the lane bank
// and write-back.
interface fma_lane_bank_if #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FMA_COUNT = 4
);
    logic [FMA_COUNT*3*WIDTH-1:0] abc_in;
    logic [FMA_COUNT-1:0]         c_valid_in;
    logic                         abc_valid_in;
    logic [FMA_COUNT*WIDTH-1:0]   result_out;
    logic                         result_valid_out;
    logic [FMA_COUNT-1:0]         overflow_out;
    logic                         busy_out;

    modport master (
        output abc_in, c_valid_in, abc_valid_in,
        input  result_out, result_valid_out, overflow_out, busy_out
    );

    modport slave (
        input  abc_in, c_valid_in, abc_valid_in,
        output result_out, result_valid_out, overflow_out, busy_out
    );
endinterface

// File: rtl/fma_lane.sv
// One multiply-add lane: stage-1 product/addend capture, stage-2 scale,
// saturate, accumulate and registered result.
module fma_lane
    import fma_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_load,
    input  logic             i_fire,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic             i_c_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_overflow
);

    logic signed [2*WIDTH-1:0] r_p;
    logic        [WIDTH-1:0]   r_c;
    logic                      r_cv;
    logic        [WIDTH-1:0]   r_acc;
    logic        [WIDTH-1:0]   r_result;
    logic                      r_overflow;

    logic signed [2*WIDTH-1:0] w_ps;
    logic        [WIDTH-1:0]   w_ps_sat;
    logic                      w_ps_clip;
    logic        [WIDTH-1:0]   w_addend;
    logic signed [WIDTH:0]     w_sum;
    logic        [WIDTH-1:0]   w_sum_sat;
    logic                      w_sum_clip;
    sat_t                      w_ps_res;
    sat_t                      w_sum_res;

    // Stage-1 capture of the full-precision product and addend selection.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_p  <= '0;
            r_c  <= '0;
            r_cv <= 1'b0;
        end else if (i_load) begin
            r_p  <= $signed(i_a) * $signed(i_b);
            r_c  <= i_c;
            r_cv <= i_c_valid;
        end else begin
            r_p  <= r_p;
            r_c  <= r_c;
            r_cv <= r_cv;
        end
    end

    // Floor-scale the product, clamp it, then add and clamp the sum.
    always_comb begin
        w_ps      = r_p >>> FRAC_BITS;
        w_ps_res  = sat_resize({{(SAT_MAX_W-2*WIDTH){w_ps[2*WIDTH-1]}}, w_ps},
                               2 * WIDTH, WIDTH);
        w_ps_sat  = WIDTH'(w_ps_res.value);
        w_ps_clip = w_ps_res.clipped;
        w_addend  = r_cv ? r_c : r_acc;
        w_sum     = $signed({w_ps_sat[WIDTH-1], w_ps_sat})
                  + $signed({w_addend[WIDTH-1], w_addend});
        w_sum_res = sat_resize({{(SAT_MAX_W-WIDTH-1){w_sum[WIDTH]}}, w_sum},
                               WIDTH + 1, WIDTH);
        w_sum_sat  = WIDTH'(w_sum_res.value);
        w_sum_clip = w_sum_res.clipped;
    end

    // Stage-2 retire: accumulator, result and overflow move together.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_acc      <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (i_fire) begin
            r_acc      <= w_sum_sat;
            r_result   <= w_sum_sat;
            r_overflow <= w_ps_clip | w_sum_clip;
        end else begin
            r_acc      <= r_acc;
            r_result   <= r_result;
            r_overflow <= r_overflow;
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/fma_lane_bank.sv
// Bank of fixed-point multiply-add lanes behind a two-stage pipeline with
// one shared beat strobe and one shared result strobe.
module fma_lane_bank
    import fma_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned FMA_COUNT = 4,
    parameter int unsigned FRAC_BITS = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    fma_lane_bank_if.slave  bus
);

    // Field layout scales with WIDTH from the default-width package layout.
    localparam int unsigned L_A      = A_LSB / DEF_WIDTH * WIDTH;
    localparam int unsigned L_B      = B_LSB / DEF_WIDTH * WIDTH;
    localparam int unsigned L_C      = C_LSB / DEF_WIDTH * WIDTH;
    localparam int unsigned L_STRIDE = LANE_STRIDE / DEF_WIDTH * WIDTH;

    state_e r_state;
    state_e w_state_next;
    logic   w_s1_valid;
    logic   w_s2_valid;

    // Pipeline occupancy register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decode stage valids and advance: stage 1 takes the beat, stage 2 takes stage 1.
    always_comb begin
        w_s1_valid   = 1'b0;
        w_s2_valid   = 1'b0;
        w_state_next = ST_IDLE;
        case (r_state)
            ST_FILL:  w_s1_valid = 1'b1;
            ST_RUN: begin
                w_s1_valid = 1'b1;
                w_s2_valid = 1'b1;
            end
            ST_DRAIN: w_s2_valid = 1'b1;
            default: begin
                w_s1_valid = 1'b0;
                w_s2_valid = 1'b0;
            end
        endcase
        case ({bus.abc_valid_in, w_s1_valid})
            2'b10:   w_state_next = ST_FILL;
            2'b11:   w_state_next = ST_RUN;
            2'b01:   w_state_next = ST_DRAIN;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.result_valid_out = w_s2_valid;
    assign bus.busy_out         = w_s1_valid | w_s2_valid;

    for (genvar g = 0; g < FMA_COUNT; g++) begin : g_lane
        fma_lane #(
            .WIDTH     (WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .i_load     (bus.abc_valid_in),
            .i_fire     (w_s1_valid),
            .i_a        (bus.abc_in[L_STRIDE*g + L_A +: WIDTH]),
            .i_b        (bus.abc_in[L_STRIDE*g + L_B +: WIDTH]),
            .i_c        (bus.abc_in[L_STRIDE*g + L_C +: WIDTH]),
            .i_c_valid  (bus.c_valid_in[g]),
            .o_result   (bus.result_out[WIDTH*g +: WIDTH]),
            .o_overflow (bus.overflow_out[g])
        );
    end

endmodule

// File: tb/tb_fma_lane_bank.sv
// Directed-vector bench for fma_lane_bank with hand-computed Q8.8 results.
module tb_fma_lane_bank;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   strobes;

    always #5 clk = ~clk;

    fma_lane_bank_if #(.WIDTH(W), .FMA_COUNT(N)) bus ();

    fma_lane_bank #(.WIDTH(W), .FMA_COUNT(N), .FRAC_BITS(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
        bus.abc_in[48*i +: 48] = {c, b, a};
    endtask

    task automatic beat_all(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [3:0] cv);
        for (int i = 0; i < N; i++) set_lane(i, a, b, c);
        bus.c_valid_in   = cv;
        bus.abc_valid_in = 1'b1;
    endtask

    task automatic idle();
        bus.abc_valid_in = 1'b0;
        bus.abc_in       = '1;
        bus.c_valid_in   = 4'hF;
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    initial begin
        bus.abc_in = '0;
        bus.c_valid_in = 4'h0;
        bus.abc_valid_in = 1'b0;
        tick();
        tick();
        check("rst_result", bus.result_out, 64'h0);
        check("rst_valid", bus.result_valid_out, 64'h0);
        check("rst_ovf", bus.overflow_out, 64'h0);
        check("rst_busy", bus.busy_out, 64'h0);
        rst = 1'b0;

        // Seed: 1.0 * 2.0 + 4.0 = 6.0
        beat_all(16'h0100, 16'h0200, 16'h0400, 4'hF);
        tick();
        idle();
        check("seed_busy", bus.busy_out, 64'h1);
        check("seed_early", bus.result_valid_out, 64'h0);
        tick();
        check("seed_valid", bus.result_valid_out, 64'h1);
        check("seed_result", bus.result_out, rep4(16'h0600));
        check("seed_ovf", bus.overflow_out, 64'h0);
        tick();

        // Accumulate twice back-to-back
        beat_all(16'h0100, 16'h0200, 16'h0000, 4'h0);
        tick();
        check("acc_gap", bus.result_valid_out, 64'h0);
        beat_all(16'h0100, 16'h0200, 16'h0000, 4'h0);
        tick();
        idle();
        check("acc1_valid", bus.result_valid_out, 64'h1);
        check("acc1_result", bus.result_out, rep4(16'h0800));
        tick();
        check("acc2_valid", bus.result_valid_out, 64'h1);
        check("acc2_result", bus.result_out, rep4(16'h0A00));
        tick();
        check("acc_drained", bus.result_valid_out, 64'h0);
        check("acc_hold", bus.result_out, rep4(16'h0A00));
        check("acc_busy", bus.busy_out, 64'h0);

        // Mixed seeding: only lane 2 seeds
        for (int i = 0; i < N; i++) set_lane(i, 16'h0100, 16'h0100, 16'h0000);
        set_lane(2, 16'h0100, 16'h0100, 16'h1000);
        bus.c_valid_in = 4'b0100;
        bus.abc_valid_in = 1'b1;
        tick();
        idle();
        tick();
        check("mix_result", bus.result_out, {16'h0B00, 16'h1100, 16'h0B00, 16'h0B00});
        check("mix_ovf", bus.overflow_out, 64'h0);

        // Product saturation, then negative floor without overflow
        beat_all(16'h7F00, 16'h7F00, 16'h0000, 4'hF);
        tick();
        beat_all(16'hFF00, 16'h0001, 16'h0000, 4'hF);
        tick();
        idle();
        check("psat_result", bus.result_out, rep4(16'h7FFF));
        check("psat_ovf", bus.overflow_out, 64'hF);
        tick();
        check("floor_result", bus.result_out, rep4(16'hFFFF));
        check("floor_ovf", bus.overflow_out, 64'h0);

        // Sum saturates negative: -128.0 + (-1/256)
        beat_all(16'h8000, 16'h0100, 16'h0000, 4'h0);
        tick();
        idle();
        tick();
        check("nsat_result", bus.result_out, rep4(16'h8000));
        check("nsat_ovf", bus.overflow_out, 64'hF);

        // Reset one cycle after a beat discards it
        beat_all(16'h0100, 16'h0100, 16'h0000, 4'h0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", bus.result_valid_out, 64'h0);
        check("mrst_busy", bus.busy_out, 64'h0);
        check("mrst_result", bus.result_out, 64'h0);
        tick();
        check("mrst_late", bus.result_valid_out, 64'h0);

        // Beat coincident with reset is dropped
        rst = 1'b1;
        beat_all(16'h0100, 16'h0100, 16'h0000, 4'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();
        check("drop_busy", bus.busy_out, 64'h0);
        tick();
        check("drop_valid", bus.result_valid_out, 64'h0);

        // Accumulator cleared by reset: 1.0 * 3.0 + 0
        beat_all(16'h0100, 16'h0300, 16'h0000, 4'h0);
        tick();
        idle();
        tick();
        check("post_valid", bus.result_valid_out, 64'h1);
        check("post_result", bus.result_out, rep4(16'h0300));

        // Beats separated by three idle cycles
        tick();
        for (int k = 0; k < 3; k++) begin
            beat_all(16'h0100, 16'h0100, 16'h0000, 4'h0);
            tick();
            idle();
            strobes = 0;
            for (int j = 0; j < 4; j++) begin
                tick();
                if (bus.result_valid_out === 1'b1) strobes++;
            end
            check("gap_strobes", 64'(strobes), 64'd1);
            check("gap_hold", bus.result_out, rep4(16'(16'h0300 + 16'h0100 * (k + 1))));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fma_lane_bank.md
# fma_lane_bank

Downstream consumer of `fma_memory_buffer`. It takes each packed all-lanes beat (`abc_out`, `c_valid_out`, `abc_valid_out`) and computes one fixed-point multiply-add per lane in a 2-stage pipeline. When a lane's `c` is valid, that lane seeds from `c`; otherwise it accumulates onto its own previous result. The per-lane results go to the write-back path as one packed word with a single valid strobe.

## Interface
- `WIDTH`, 16: bit width of signed two's-complement operands and results.
- `FMA_COUNT`, 4: number of lanes.
- `FRAC_BITS`, 8: fractional bits of the fixed-point format (Q(WIDTH-FRAC_BITS).FRAC_BITS).
- `clk_in` input 1: single clock; all state changes on the rising edge.
- `rst_in` input 1: reset, synchronous and active-high.
- `abc_in` input FMA_COUNT*3*WIDTH: lane i uses `[3*WIDTH*i +: 3*WIDTH]`; within the lane, `a` is the low WIDTH bits, `b` the middle WIDTH bits, `c` the top WIDTH bits.
- `c_valid_in` input FMA_COUNT: bit i high means lane i seeds from its `c` on this beat.
- `abc_valid_in` input 1: one-cycle beat strobe for all lanes.
- `result_out` output FMA_COUNT*WIDTH: lane i result at `[WIDTH*i +: WIDTH]`.
- `result_valid_out` output 1: one-cycle strobe; `result_out` is valid in that cycle.
- `overflow_out` output FMA_COUNT: per-lane saturation flag, qualified by `result_valid_out`.
- `busy_out` output 1: high while any beat is in flight in the pipeline.

## Operation
- **Stage 1 (on `abc_valid_in`):** per lane, register the full-precision product `p = a*b` (signed, 2*WIDTH bits), `c`, and `c_valid_in`. Set the stage-1 valid bit.
- **Stage 2:**
  - Scale: `ps = p >>> FRAC_BITS` (arithmetic shift, floor rounding).
  - Saturate `ps` to the WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Addend = `c` if the registered `c_valid` bit is set, else the lane accumulator `acc`.
  - Compute `sum = sat(ps) + addend` at WIDTH+1 bits, then saturate to WIDTH.
  - `acc`, `result_out` and `overflow_out` all take the stage-2 outcome.
  - `overflow_out[i]` = 1 if either saturation (product or sum) clipped.
- **No hazard on back-to-back beats:** stage 2 of beat N+1 reads `acc` one cycle after beat N wrote it.
- **Beat with `c_valid_in = 0` on a lane:** that lane accumulates. After reset, `acc` = 0, so the first accumulate equals `sat(ps)`.
- **No backpressure.** The bank accepts one beat every cycle. The upstream buffer never stalls on this block.
- **States:**
  - IDLE: no stage valid.
  - FILL: stage 1 only valid.
  - RUN: both stages valid.
  - DRAIN: stage 2 only valid.
  - Transitions are fully determined by `abc_valid_in` and the stage valid bits.
  - `busy_out` = stage-1 valid OR stage-2 valid.

## Timing
- **Latency:** `abc_valid_in` in cycle T gives `result_valid_out` in cycle T+2. Throughput is 1 beat per cycle.
- **Reset values:**
  - `result_out` = 0, `result_valid_out` = 0, `overflow_out` = 0, `busy_out` = 0.
  - All `acc` = 0, both stage valid bits = 0.
- **Reset mid-operation:** `rst_in` high in any cycle discards every in-flight beat. No `result_valid_out` is produced for those beats, and `acc` clears. A beat presented in the same cycle as `rst_in` is dropped.
- **`abc_valid_in` low:** `abc_in` and `c_valid_in` are ignored. `result_out` holds its last value. `result_valid_out` is 0 when no beat leaves stage 2.
- **Simultaneous events:** a new beat entering stage 1 while stage 2 retires is the normal RUN case; nothing is lost.

## Structure
- **Shared package `fma_pkg`:**
  - Lane field offset constants (A_LSB = 0, B_LSB = WIDTH, C_LSB = 2*WIDTH).
  - Lane stride constant.
  - A saturating-resize function, parameterised by input and output width.
- **Sub-module `fma_lane`:**
  - One lane: product register, c/c_valid registers, `acc`, overflow logic.
  - Instantiated FMA_COUNT times in a generate loop.
  - The stage valid bits and `busy_out` stay in the top level.

## Test plan
All scenarios use WIDTH=16, FRAC_BITS=8, FMA_COUNT=4.
- **Seed:** all lanes a=0x0100, b=0x0200, c=0x0400, `c_valid_in`=4'b1111 -> 2 cycles later `result_valid_out`=1, every lane 0x0600, `overflow_out`=0.
- **Accumulate:** next beat, same a/b, `c_valid_in`=0 -> every lane 0x0800. A further identical beat (back-to-back) -> 0x0A00 on consecutive result cycles.
- **Mixed seeding:** `c_valid_in`=4'b0100, lane 2 c=0x1000, a=0x0100, b=0x0100 -> lane 2 = 0x1100; lanes 0, 1, 3 = previous acc + 0x0100.
- **Saturation:**
  - a=b=0x7F00 -> 0x7FFF, `overflow_out` bit set.
  - a=0xFF00 (-1.0), b=0x0001 -> product floors to 0xFFFF (-1/256), no overflow.
- **Reset mid-pipeline:** beat at T, `rst_in` at T+1 -> no `result_valid_out` at T+2, `busy_out`=0 at T+2. A following `c_valid_in`=0 beat with a=0x0100, b=0x0300 -> result 0x0300.
- **Idle gaps:** beats separated by 3 idle cycles -> exactly one strobe per beat, and `result_out` holds between strobes.
